// File: rtl/scanner_receiver.sv
// scanner_receiver: deserializes the scanner's clkOut/dataOut stream and decodes commands/data bytes.
// Optional idle-timeout on partial bytes is enabled by defining SCANNER_RX_TIMEOUT_EN.
module scanner_receiver #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serialClkIn,
  input  logic       serialDataIn,
  output logic       cmdReady,
  output logic       cmdStart,
  output logic       cmdFull,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       cmdError,
  output logic [7:0] byteCount,
  output logic       readyForTransferOut
);
  typedef enum logic {WAIT_CMD, WAIT_DATA} state_t;
  logic [1:0] rst_sync_q;
  logic       rst_n;
  logic [1:0] sck_q, sd_q;
  logic       sck_prev_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       smp, byte_done, is_cmd, is_data, pend, timeout;
  state_t     state_q, state_d;
  // Assert asynchronously, release two clk edges later.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync_q <= 2'b00;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  always_comb begin
    smp       = sck_q[1] & ~sck_prev_q;
    shift_d   = smp ? {shift_q[6:0], sd_q[1]} : shift_q;
    byte_done = smp && bit_cnt_q == 3'd7;
    bit_cnt_d = timeout ? 3'd0 : smp ? bit_cnt_q + 3'd1 : bit_cnt_q;
    is_cmd    = byte_done && state_q == WAIT_CMD;
    is_data   = byte_done && state_q == WAIT_DATA;
    pend      = is_data || (is_cmd && shift_d inside {8'd2, 8'd3, 8'd4});
    state_d   = timeout ? WAIT_CMD :
                (is_cmd && shift_d == 8'd7) ? WAIT_DATA :
                is_data ? WAIT_CMD : state_q;
  end
`ifdef SCANNER_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;
  assign timeout = !smp && bit_cnt_q != 3'd0 && idle_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_q <= '0;
    else idle_q <= (smp || bit_cnt_q == 3'd0 || timeout) ? '0 : idle_q + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_q      <= '0;
      sd_q       <= '0;
      sck_prev_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
    end else begin
      sck_q      <= {sck_q[0], serialClkIn};
      sd_q       <= {sd_q[0], serialDataIn};
      sck_prev_q <= sck_q[1];
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q             <= WAIT_CMD;
      cmdReady            <= 1'b0;
      cmdStart            <= 1'b0;
      cmdFull             <= 1'b0;
      rxValid             <= 1'b0;
      rxData              <= '0;
      byteCount           <= '0;
      cmdError            <= 1'b0;
      readyForTransferOut <= 1'b1;
    end else begin
      state_q             <= state_d;
      cmdReady            <= is_cmd && shift_d == 8'd2;
      cmdStart            <= is_cmd && shift_d == 8'd3;
      cmdFull             <= is_cmd && shift_d == 8'd4;
      rxValid             <= is_data;
      cmdError            <= cmdError | (is_cmd && !(shift_d inside {8'd2, 8'd3, 8'd4, 8'd7}));
      readyForTransferOut <= state_d == WAIT_CMD && !pend;
      if (is_data) begin
        rxData    <= shift_d;
        byteCount <= byteCount + {7'd0, byteCount != 8'hFF};
      end
    end
endmodule

// File: tb/tb_scanner_receiver.sv
// tb_scanner_receiver: table-driven bytes plus hand-written corner sequences; pulses are
// checked against a queue of expected events filled as each byte is driven.
`timescale 1ns/1ps
module tb_scanner_receiver;
  logic clk = 0, rst = 0, sck = 0, sd = 0;
  logic cmdReady, cmdStart, cmdFull, rxValid, cmdError, readyForTransferOut;
  logic [7:0] rxData, byteCount;
  always #5 clk = ~clk;
  scanner_receiver #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .serialClkIn(sck), .serialDataIn(sd),
    .cmdReady(cmdReady), .cmdStart(cmdStart), .cmdFull(cmdFull),
    .rxData(rxData), .rxValid(rxValid), .cmdError(cmdError),
    .byteCount(byteCount), .readyForTransferOut(readyForTransferOut)
  );
  // kind: 0 none, 1 ready, 2 start, 3 full, 4 data
  typedef struct {int kind; logic [7:0] data; logic [7:0] cnt;} ev_t;
  typedef struct {logic [7:0] b; int kind; logic err; logic rdy;} vec_t;
  ev_t q[$];
  vec_t tbl[13];
  int pass_n = 0, total_n = 0, rx_pulses = 0, mon_k, first;
  ev_t mon_e;
  logic [7:0] exp_cnt = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic push(input int kind, input logic [7:0] b);
    if (kind == 4) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    q.push_back('{kind, b, exp_cnt});
  endtask
  task automatic send_bit(input logic b);
    @(posedge clk); #1 sd = b;
    @(posedge clk); #1 sck = 1;
    repeat (2) @(posedge clk);
    #1 sck = 0;
    repeat (2) @(posedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask
  task automatic settle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
  endtask
  always @(negedge clk)
    if (cmdReady | cmdStart | cmdFull | rxValid) begin
      check("onehot_pulses", $countones({cmdReady, cmdStart, cmdFull, rxValid}), 1);
      check("ready_low_during_pulse", readyForTransferOut, 0);
      mon_k = cmdReady ? 1 : cmdStart ? 2 : cmdFull ? 3 : 4;
      if (rxValid) rx_pulses++;
      if (q.size() == 0) check("unexpected_pulse", mon_k, 0);
      else begin
        mon_e = q.pop_front();
        check("pulse_kind", mon_k, mon_e.kind);
        if (mon_k == 4) begin
          check("rxData", rxData, mon_e.data);
          check("byteCount", byteCount, mon_e.cnt);
        end
      end
    end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{8'd2,   1, 1'b0, 1'b1};
    tbl[1]  = '{8'd3,   2, 1'b0, 1'b1};
    tbl[2]  = '{8'd4,   3, 1'b0, 1'b1};
    tbl[3]  = '{8'd7,   0, 1'b0, 1'b0};
    tbl[4]  = '{8'hA5,  4, 1'b0, 1'b1};
    tbl[5]  = '{8'd7,   0, 1'b0, 1'b0};
    tbl[6]  = '{8'd7,   4, 1'b0, 1'b1};
    tbl[7]  = '{8'd7,   0, 1'b0, 1'b0};
    tbl[8]  = '{8'd2,   4, 1'b0, 1'b1};
    tbl[9]  = '{8'd9,   0, 1'b1, 1'b1};
    tbl[10] = '{8'd3,   2, 1'b1, 1'b1};
    tbl[11] = '{8'd0,   0, 1'b1, 1'b1};
    tbl[12] = '{8'hFF,  0, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pulses", {cmdReady, cmdStart, cmdFull, rxValid}, 0);
    check("reset_rxData", rxData, 0);
    check("reset_byteCount", byteCount, 0);
    check("reset_cmdError", cmdError, 0);
    check("reset_ready", readyForTransferOut, 1);
    @(posedge clk); #1 rst = 1;
    repeat (4) @(posedge clk);
    // cmdReady latency: 2 sync flops + 1 registered decode after the bit-0 clock rise
    push(1, 8'd2);
    for (int i = 7; i >= 1; i--) send_bit(i == 1);
    @(posedge clk); #1 sd = 0;
    @(posedge clk); #1 sck = 1;
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (cmdReady && first == 0) first = k;
    end
    check("ready_latency", first, 3);
    @(posedge clk); #1 sck = 0;
    repeat (2) @(posedge clk);
    settle();
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].kind != 0) push(tbl[i].kind, tbl[i].b);
      send_byte(tbl[i].b);
      settle();
      check("cmdError", cmdError, tbl[i].err);
      check("readyForTransfer", readyForTransferOut, tbl[i].rdy);
    end
    // reset in the middle of a byte
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    @(posedge clk); #1 rst = 0;
    #2;
    check("async_clear_cmdError", cmdError, 0);
    check("async_clear_byteCount", byteCount, 0);
    check("async_ready", readyForTransferOut, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    exp_cnt = 0;
    repeat (4) @(posedge clk);
    push(3, 8'd4);
    send_byte(8'd4);
    settle();
    check("post_reset_cmdError", cmdError, 0);
    rx_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'd7);
      push(4, 8'(i));
      send_byte(8'(i));
    end
    settle();
    check("saturated_byteCount", byteCount, 8'hFF);
    check("rxValid_pulse_count", rx_pulses, 256);
    check("pairs_ready", readyForTransferOut, 1);
    // partial byte followed by a long idle gap
    send_bit(1); send_bit(1); send_bit(1);
    repeat (70) @(posedge clk);
`ifdef SCANNER_RX_TIMEOUT_EN
    push(1, 8'd2);
    send_byte(8'd2);
    settle();
    check("timeout_no_error", cmdError, 0);
`else
    send_byte(8'd2);
    settle();
    check("misaligned_error", cmdError, 1);
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
